// File: rtl/axis_tdest_demux.sv
// Two-way AXI4-Stream packet demultiplexer steered by tdest[0], locked per packet.
// A two-entry register slice (output + skid) decouples input ready from output ready.
module axis_tdest_demux #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEST_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic [DEST_WIDTH-1:0]  s_tdest,

  output logic                   m0_tvalid,
  input  logic                   m0_tready,
  output logic                   m0_tlast,
  output logic [DATA_WIDTH-1:0]  m0_tdata,

  output logic                   m1_tvalid,
  input  logic                   m1_tready,
  output logic                   m1_tlast,
  output logic [DATA_WIDTH-1:0]  m1_tdata,

  output logic [COUNT_WIDTH-1:0] pkt_count0,
  output logic [COUNT_WIDTH-1:0] pkt_count1,
  output logic                   dest_err
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  sel;
  } beat_t;

  // Slice state
  logic  out_valid_q, out_valid_d;
  beat_t out_beat_q, out_beat_d;
  logic  skid_valid_q, skid_valid_d;
  beat_t skid_beat_q, skid_beat_d;
  logic  s_tready_q, s_tready_d;

  // Packet lock and status state
  logic                   in_pkt_q, in_pkt_d;
  logic                   lock_sel_q, lock_sel_d;
  logic                   dest_err_q, dest_err_d;
  logic [COUNT_WIDTH-1:0] count0_q, count0_d;
  logic [COUNT_WIDTH-1:0] count1_q, count1_d;

  logic  s_accept;
  logic  beat_sel;
  logic  out_ready;
  logic  ready_o;
  logic  out_fire;
  beat_t in_beat;

  // Only bit 0 of tdest participates in routing.
  logic unused_dest;
  assign unused_dest = ^s_tdest;

  always_comb begin
    s_accept     = s_tvalid & s_tready_q;
    beat_sel     = in_pkt_q ? lock_sel_q : s_tdest[0];
    in_beat.data = s_tdata;
    in_beat.last = s_tlast;
    in_beat.sel  = beat_sel;
    out_ready    = out_beat_q.sel ? m1_tready : m0_tready;
    ready_o      = ~out_valid_q | out_ready;
    out_fire     = out_valid_q & out_ready;
  end

  // Register slice. An accepted beat always finds the skid empty, because
  // s_tready is the registered inverse of skid occupancy.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_beat_d   = out_beat_q;
    skid_valid_d = skid_valid_q;
    skid_beat_d  = skid_beat_q;
    if (ready_o) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_beat_d   = skid_beat_q;
        skid_valid_d = 1'b0;
      end else if (s_accept) begin
        out_valid_d = 1'b1;
        out_beat_d  = in_beat;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (s_accept) begin
      skid_valid_d = 1'b1;
      skid_beat_d  = in_beat;
    end
    s_tready_d = ~skid_valid_d;
  end

  always_comb begin
    in_pkt_d   = in_pkt_q;
    lock_sel_d = lock_sel_q;
    dest_err_d = dest_err_q;
    if (s_accept) begin
      in_pkt_d = ~s_tlast;
      if (!in_pkt_q) begin
        lock_sel_d = s_tdest[0];
      end else if (s_tdest[0] != lock_sel_q) begin
        dest_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    count0_d = count0_q;
    count1_d = count1_q;
    if (out_fire && out_beat_q.last) begin
      if (out_beat_q.sel) begin
        count1_d = count1_q + COUNT_WIDTH'(1);
      end else begin
        count0_d = count0_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_beat_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_beat_q  <= '0;
      s_tready_q   <= 1'b0;
      in_pkt_q     <= 1'b0;
      lock_sel_q   <= 1'b0;
      dest_err_q   <= 1'b0;
      count0_q     <= '0;
      count1_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_beat_q   <= out_beat_d;
      skid_valid_q <= skid_valid_d;
      skid_beat_q  <= skid_beat_d;
      s_tready_q   <= s_tready_d;
      in_pkt_q     <= in_pkt_d;
      lock_sel_q   <= lock_sel_d;
      dest_err_q   <= dest_err_d;
      count0_q     <= count0_d;
      count1_q     <= count1_d;
    end
  end

  always_comb begin
    s_tready   = s_tready_q;
    m0_tvalid  = out_valid_q & ~out_beat_q.sel;
    m1_tvalid  = out_valid_q & out_beat_q.sel;
    m0_tdata   = out_beat_q.data;
    m1_tdata   = out_beat_q.data;
    m0_tlast   = out_beat_q.last;
    m1_tlast   = out_beat_q.last;
    pkt_count0 = count0_q;
    pkt_count1 = count1_q;
    dest_err   = dest_err_q;
  end

endmodule

// File: tb/tb_axis_tdest_demux.sv
// Directed bench for axis_tdest_demux: routing, slice backpressure, lock errors,
// counter wrap and mid-packet reset.
module tb_axis_tdest_demux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [31:0] s_tdest = '0;
  logic        m0_tvalid, m1_tvalid;
  logic        m0_tready = 1'b1;
  logic        m1_tready = 1'b1;
  logic        m0_tlast, m1_tlast;
  logic [31:0] m0_tdata, m1_tdata;
  logic [15:0] pkt_count0, pkt_count1;
  logic        dest_err;

  axis_tdest_demux #(
    .DATA_WIDTH (32),
    .DEST_WIDTH (32),
    .COUNT_WIDTH(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .s_tdata   (s_tdata),
    .s_tdest   (s_tdest),
    .m0_tvalid (m0_tvalid),
    .m0_tready (m0_tready),
    .m0_tlast  (m0_tlast),
    .m0_tdata  (m0_tdata),
    .m1_tvalid (m1_tvalid),
    .m1_tready (m1_tready),
    .m1_tlast  (m1_tlast),
    .m1_tdata  (m1_tdata),
    .pkt_count0(pkt_count0),
    .pkt_count1(pkt_count1),
    .dest_err  (dest_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Monitor state, sampled on the falling edge
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  int          acc_n, del_n, max_occ, stab_err;
  int          first_acc, first_hs, last_hs;
  logic        m1_seen;
  logic        held0_v, held1_v;
  logic [32:0] held0, held1;
  logic        bp_done;
  logic [15:0] exp0 = '0;
  logic [15:0] exp1 = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      held0_v = 1'b0;
      held1_v = 1'b0;
    end else begin
      if (s_tvalid && s_tready) begin
        acc_n++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (held0_v && m0_tvalid && ({m0_tlast, m0_tdata} != held0)) stab_err++;
      if (held1_v && m1_tvalid && ({m1_tlast, m1_tdata} != held1)) stab_err++;
      held0_v = m0_tvalid && !m0_tready;
      held1_v = m1_tvalid && !m1_tready;
      held0   = {m0_tlast, m0_tdata};
      held1   = {m1_tlast, m1_tdata};
      if (m1_tvalid) m1_seen = 1'b1;
      if (m0_tvalid && m0_tready) begin
        q0.push_back({m0_tlast, m0_tdata});
        del_n++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (m1_tvalid && m1_tready) begin
        q1.push_back({m1_tlast, m1_tdata});
        del_n++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (acc_n - del_n > max_occ) max_occ = acc_n - del_n;
    end
  end

  task automatic clear_mon();
    q0.delete();
    q1.delete();
    acc_n = 0; del_n = 0; max_occ = 0; stab_err = 0;
    first_acc = -1; first_hs = -1; last_hs = -1;
    m1_seen = 1'b0;
  endtask

  // Presents one beat and returns #1 after the edge that accepts it.
  task automatic drive_beat(input logic [31:0] d, input logic dst, input logic l);
    int k;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tdest  = {31'b0, dst};
    s_tlast  = l;
    k = 0;
    @(negedge clk);
    while (!s_tready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!s_tready) begin
      n_checks++;
      $display("FAIL accept_timeout: s_tready=%b after %0d cycles, required 1", s_tready, k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input logic d0, input int chg);
    for (int i = 0; i < n; i++) begin
      drive_beat(base + 32'(i), (i == chg) ? ~d0 : d0, i == n - 1);
    end
  endtask

  task automatic idle_input();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int expected, input int bound);
    int k = 0;
    while (del_n < expected && k < bound) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (del_n < expected) $display("FAIL drain_timeout: delivered %0d, required %0d", del_n, expected);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({s_tready, m0_tvalid, m1_tvalid, m0_tlast, m1_tlast} !== 5'b0)
      $display("FAIL rst_ctrl: got %b required 00000",
               {s_tready, m0_tvalid, m1_tvalid, m0_tlast, m1_tlast});
    else n_pass++;
    n_checks++;
    if ({m0_tdata, m1_tdata} !== 64'h0) $display("FAIL rst_data: got %h required 0", {m0_tdata, m1_tdata});
    else n_pass++;
    n_checks++;
    if ({pkt_count0, pkt_count1, dest_err} !== 33'h0)
      $display("FAIL rst_status: got %h/%h/%b required 0/0/0", pkt_count0, pkt_count1, dest_err);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (s_tready !== 1'b0) $display("FAIL rst_release_ready: got %b required 0", s_tready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (s_tready !== 1'b1) $display("FAIL rst_ready_rise: got %b required 1", s_tready);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int n = 0;
    int k = 0;
    clear_mon();
    s_tvalid = 1'b1;
    s_tdest  = 32'd1;
    s_tlast  = 1'b1;
    s_tdata  = 32'h77;
    while (n < 65537 && k < 70000) begin
      @(negedge clk);
      k++;
      if (s_tready) n++;
    end
    @(posedge clk);
    #1;
    idle_input();
    wait_drain(65537, 2000);
    exp1 = 16'd1;
    n_checks++;
    if (pkt_count1 !== 16'd1) $display("FAIL wrap_count1: got %0d required 1", pkt_count1);
    else n_pass++;
    n_checks++;
    if (pkt_count0 !== 16'd0) $display("FAIL wrap_count0: got %0d required 0", pkt_count0);
    else n_pass++;
    n_checks++;
    if (q1.size() != 65537 || q0.size() != 0)
      $display("FAIL wrap_beats: got m1=%0d m0=%0d required 65537/0", q1.size(), q0.size());
    else n_pass++;
  endtask

  // Checks the 16-beat alternating pattern collected by the monitor.
  task automatic check_alt_queues(input string tag);
    n_checks++;
    if (q0.size() != 8 || q1.size() != 8)
      $display("FAIL %s_sizes: got %0d/%0d required 8/8", tag, q0.size(), q1.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        logic [32:0] e0, e1;
        e0 = {(i % 4) == 3, 32'((i < 4) ? i : i + 4)};
        e1 = {(i % 4) == 3, 32'((i < 4) ? i + 4 : i + 8)};
        n_checks++;
        if (q0[i] !== e0) $display("FAIL %s_m0[%0d]: got %h required %h", tag, i, q0[i], e0);
        else n_pass++;
        n_checks++;
        if (q1[i] !== e1) $display("FAIL %s_m1[%0d]: got %h required %h", tag, i, q1[i], e1);
        else n_pass++;
      end
    end
    n_checks++;
    if (pkt_count0 !== exp0 || pkt_count1 !== exp1)
      $display("FAIL %s_counts: got %0d/%0d required %0d/%0d", tag, pkt_count0, pkt_count1,
               exp0, exp1);
    else n_pass++;
  endtask

  task automatic test_alternating();
    m0_tready = 1'b1;
    m1_tready = 1'b1;
    clear_mon();
    for (int p = 0; p < 4; p++) send_pkt(4, 32'(p * 4), p[0], -1);
    idle_input();
    wait_drain(16, 100);
    exp0 += 16'd2;
    exp1 += 16'd2;
    check_alt_queues("alt");
    n_checks++;
    if (last_hs - first_hs != 15) $display("FAIL alt_bubbles: span %0d required 15", last_hs - first_hs);
    else n_pass++;
    n_checks++;
    if (first_hs - first_acc != 1) $display("FAIL alt_latency: got %0d required 1", first_hs - first_acc);
    else n_pass++;
    n_checks++;
    if (dest_err !== 1'b0) $display("FAIL alt_dest_err: got %b required 0", dest_err);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    m1_tready = 1'b1;
    m0_tready = 1'b1;
    bp_done   = 1'b0;
    clear_mon();
    fork
      begin
        for (int p = 0; p < 4; p++) send_pkt(4, 32'(p * 4), p[0], -1);
        idle_input();
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #2;
          m0_tready = ~m0_tready;
        end
      end
    join
    m0_tready = 1'b1;
    wait_drain(16, 200);
    exp0 += 16'd2;
    exp1 += 16'd2;
    check_alt_queues("bp");
    n_checks++;
    if (max_occ != 2) $display("FAIL bp_occupancy: got %0d required 2", max_occ);
    else n_pass++;
    n_checks++;
    if (stab_err != 0) $display("FAIL bp_stability: got %0d changes required 0", stab_err);
    else n_pass++;
    n_checks++;
    if (s_tready !== 1'b1) $display("FAIL bp_ready_return: got %b required 1", s_tready);
    else n_pass++;
  endtask

  task automatic test_dest_change();
    clear_mon();
    send_pkt(4, 32'h20, 1'b0, 1);
    idle_input();
    wait_drain(4, 100);
    exp0 += 16'd1;
    n_checks++;
    if (q0.size() != 4 || q1.size() != 0)
      $display("FAIL chg_route: got m0=%0d m1=%0d required 4/0", q0.size(), q1.size());
    else begin
      n_pass++;
      n_checks++;
      if (q0[1] !== {1'b0, 32'h21}) $display("FAIL chg_beat2: got %h required 021", q0[1]);
      else n_pass++;
    end
    n_checks++;
    if (dest_err !== 1'b1) $display("FAIL chg_err_set: got %b required 1", dest_err);
    else n_pass++;
    send_pkt(2, 32'h30, 1'b1, -1);
    idle_input();
    wait_drain(6, 100);
    exp1 += 16'd1;
    n_checks++;
    if (q1.size() != 2) $display("FAIL chg_clean_pkt: got %0d beats on m1 required 2", q1.size());
    else n_pass++;
    n_checks++;
    if (dest_err !== 1'b1) $display("FAIL chg_err_sticky: got %b required 1", dest_err);
    else n_pass++;
    n_checks++;
    if (pkt_count0 !== exp0 || pkt_count1 !== exp1)
      $display("FAIL chg_counts: got %0d/%0d required %0d/%0d", pkt_count0, pkt_count1, exp0, exp1);
    else n_pass++;
  endtask

  task automatic test_stalled_other();
    m1_tready = 1'b0;
    clear_mon();
    send_pkt(4, 32'h40, 1'b0, -1);
    send_pkt(4, 32'h44, 1'b0, -1);
    idle_input();
    wait_drain(8, 100);
    exp0 += 16'd2;
    n_checks++;
    if (m1_seen !== 1'b0) $display("FAIL stall_m1_valid: got %b required 0", m1_seen);
    else n_pass++;
    n_checks++;
    if (last_hs - first_hs != 7) $display("FAIL stall_throughput: span %0d required 7", last_hs - first_hs);
    else n_pass++;
    n_checks++;
    if (q0.size() != 8 || pkt_count0 !== exp0)
      $display("FAIL stall_m0: got %0d beats count %0d required 8/%0d", q0.size(), pkt_count0, exp0);
    else n_pass++;
    m1_tready = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    m1_tready = 1'b0;
    clear_mon();
    drive_beat(32'h50, 1'b1, 1'b0);
    drive_beat(32'h51, 1'b1, 1'b0);
    idle_input();
    n_checks++;
    if (m1_tvalid !== 1'b1 || m1_tdata !== 32'h50)
      $display("FAIL rmp_pre: got valid %b data %h required 1/00000050", m1_tvalid, m1_tdata);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({s_tready, m0_tvalid, m1_tvalid, m1_tlast} !== 4'b0 || m1_tdata !== 32'h0)
      $display("FAIL rmp_outputs: got %b data %h required 0000/0",
               {s_tready, m0_tvalid, m1_tvalid, m1_tlast}, m1_tdata);
    else n_pass++;
    n_checks++;
    if ({pkt_count0, pkt_count1, dest_err} !== 33'h0)
      $display("FAIL rmp_status: got %0d/%0d/%b required 0/0/0", pkt_count0, pkt_count1, dest_err);
    else n_pass++;
    exp0 = '0;
    exp1 = '0;
    m1_tready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (s_tready !== 1'b1) $display("FAIL rmp_ready_rise: got %b required 1", s_tready);
    else n_pass++;
    clear_mon();
    drive_beat(32'h60, 1'b0, 1'b1);
    idle_input();
    wait_drain(1, 50);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (q0.size() != 1 || q1.size() != 0)
      $display("FAIL rmp_route: got m0=%0d m1=%0d required 1/0", q0.size(), q1.size());
    else begin
      n_pass++;
      n_checks++;
      if (q0[0] !== {1'b1, 32'h60}) $display("FAIL rmp_beat: got %h required 100000060", q0[0]);
      else n_pass++;
    end
    n_checks++;
    if (pkt_count0 !== 16'd1 || pkt_count1 !== 16'd0)
      $display("FAIL rmp_counts: got %0d/%0d required 1/0", pkt_count0, pkt_count1);
    else n_pass++;
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_wrap();
    test_alternating();
    test_backpressure();
    test_dest_change();
    test_stalled_other();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
